gpio_event_logger: RTL and testbench
====================================

GPIO_EVENT_LOGGER -- requirements
Module: gpio_event_logger

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16: event FIFO entries, power of two.
REQ-002 SHALL have parameter DATA_W, default 32: GPIO and timestamp width.
REQ-003 SHALL have port clk_main_200mhz  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port gpio_data_in  input  DATA_W  registered GPIO output word from the GPIO stage.
REQ-006 SHALL have port timestamp_in  input  DATA_W  free-running main-domain cycle counter.
REQ-007 SHALL have port log_enable  input  1  level; permits event capture.
REQ-008 SHALL have port freeze_on_ovf  input  1  selects freeze on first drop.
REQ-009 SHALL have port evt_mask  input  DATA_W  per-bit change-detect enable.
REQ-010 SHALL have port evt_data  output  2*DATA_W  head entry {timestamp, gpio}.
REQ-011 SHALL have port evt_valid  output  1  head entry available.
REQ-012 SHALL have port evt_ready  input  1  consumer accepts head entry.
REQ-013 SHALL have port fifo_level  output  log2(FIFO_DEPTH)+1  occupied entries.
REQ-014 SHALL have port overflow_flag  output  1  sticky; an event was dropped.
REQ-015 SHALL have port overflow_clear  input  1  single-cycle clear of overflow_flag and drop_count.
REQ-016 SHALL have port drop_count  output  16  dropped events, saturating.
REQ-017 SHALL have port irq_out  output  1  level interrupt = evt_valid OR overflow_flag.
REQ-018 SHALL have port log_state  output  2  current FSM state encoding.

Function
REQ-019 SHALL register gpio_data_in every cycle into prev_gpio, regardless of state.
REQ-020 SHALL detect an event in a cycle when ((gpio_data_in XOR prev_gpio) AND evt_mask) is nonzero and state is LOGGING.
REQ-021 SHALL form the entry as {timestamp_in, gpio_data_in} from the same detection cycle.
REQ-022 SHALL make a pushed entry visible at evt_data/evt_valid one cycle after detection when the FIFO was empty (show-ahead).
REQ-023 SHALL complete a transfer when evt_valid and evt_ready are both high; head advances next cycle.
REQ-024 SHALL hold evt_data stable while evt_valid is high and evt_ready is low.
REQ-025 SHALL accept a push when full if a pop occurs in the same cycle; level unchanged.
REQ-026 SHALL drop the event when full with no simultaneous pop: set overflow_flag, increment drop_count.
REQ-027 SHALL saturate drop_count at 16'hFFFF.
REQ-028 SHALL give a new drop priority over overflow_clear in the same cycle (flag stays 1, drop_count = 1).
REQ-029 SHALL use FSM states IDLE=0, LOGGING=1, FROZEN=2.
REQ-030 SHALL transition IDLE->LOGGING when log_enable=1; LOGGING->IDLE when log_enable=0.
REQ-031 SHALL transition LOGGING->FROZEN on a drop when freeze_on_ovf=1; FROZEN->IDLE on overflow_clear.
REQ-032 SHALL stop pushing in IDLE and FROZEN while continuing to drain the FIFO.
REQ-033 SHALL keep fifo_level in 0..FIFO_DEPTH with wrap-around read/write pointers.

Reset
REQ-034 SHALL, while reset_n=0, asynchronously force: state IDLE, prev_gpio 0, pointers 0, fifo_level 0, evt_valid 0, evt_data 0, overflow_flag 0, drop_count 0, irq_out 0.
REQ-035 SHALL discard all FIFO contents on reset asserted mid-operation; no partial transfer survives.
REQ-036 SHALL not detect an event in the first cycle after reset release (state still IDLE).

Structure
REQ-037 SHALL place the state enum, FIFO_DEPTH default and entry-width constant in package gpio_event_logger_pkg.
REQ-038 SHALL instantiate one sub-module, sync_fifo (show-ahead, parameterised depth and width, full/empty/level).

Verification
REQ-039 SHALL cover: log_enable=1, mask 0x0000_00FF, gpio 0->0x01 at timestamp 100 -> evt_data {100, 0x01}, evt_valid one cycle later, irq_out 1.
REQ-040 SHALL cover: gpio change only in bit 16 with mask 0x0000_FFFF -> no entry, fifo_level 0.
REQ-041 SHALL cover: 17 events, evt_ready=0, freeze_on_ovf=0 -> fifo_level 16, overflow_flag 1, drop_count 1, state LOGGING.
REQ-042 SHALL cover: full FIFO, push with evt_ready=1 same cycle -> no drop, level 16, order preserved.
REQ-043 SHALL cover: freeze_on_ovf=1, overflow -> FROZEN, further changes ignored; overflow_clear -> IDLE, flag 0, drop_count 0.
REQ-044 SHALL cover: reset_n pulsed with 5 entries queued -> fifo_level 0, evt_valid 0, all outputs at REQ-034 values.

Source files
------------

// File: rtl/gpio_event_logger_pkg.sv
// Shared types and constants for the GPIO event logger.
package gpio_event_logger_pkg;

    // Logger FSM states; the encoding is exported on log_state.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOGGING = 2'd1,
        ST_FROZEN  = 2'd2
    } log_state_e;

    localparam int FIFO_DEPTH_DEFAULT = 16;
    localparam int DATA_W_DEFAULT     = 32;

    // One FIFO entry holds {timestamp, gpio}.
    function automatic int entry_width(input int data_w);
        return 2 * data_w;
    endfunction

    localparam int ENTRY_W_DEFAULT = entry_width(DATA_W_DEFAULT);

    localparam logic [15:0] DROP_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/gpio_event_logger_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is presented on pop_data
// whenever the FIFO is not empty. DEPTH must be a power of two so the
// pointers wrap naturally.
module sync_fifo
    import gpio_event_logger_pkg::*;
#(
    parameter  int DEPTH = FIFO_DEPTH_DEFAULT,
    parameter  int WIDTH = ENTRY_W_DEFAULT,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk_main_200mhz,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    localparam logic [LW-1:0] FULL_COUNT = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign level   = count;
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    // Head entry is zero while empty so nothing stale is ever presented.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Entry storage write.
    // NOTE: the array has no reset; emptiness is tracked by count, so clearing
    // the storage would only add a reset net to every bit for no benefit.
    always_ff @(posedge clk_main_200mhz) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: non-blocking assignments so every flop samples pre-edge values
    // regardless of statement order.
    always_ff @(posedge clk_main_200mhz or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gpio_event_logger.sv
// GPIO event logger: timestamps masked GPIO changes into a show-ahead FIFO,
// tracks dropped events and can freeze capture on the first drop.
module gpio_event_logger
    import gpio_event_logger_pkg::*;
#(
    parameter  int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter  int DATA_W     = DATA_W_DEFAULT,
    localparam int ENTRY_W    = entry_width(DATA_W),
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk_main_200mhz,
    input  logic                 reset_n,
    input  logic [DATA_W-1:0]    gpio_data_in,
    input  logic [DATA_W-1:0]    timestamp_in,
    input  logic                 log_enable,
    input  logic                 freeze_on_ovf,
    input  logic [DATA_W-1:0]    evt_mask,
    output logic [ENTRY_W-1:0]   evt_data,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [LVL_W-1:0]     fifo_level,
    output logic                 overflow_flag,
    input  logic                 overflow_clear,
    output logic [15:0]          drop_count,
    output logic                 irq_out,
    output logic [1:0]           log_state
);

    log_state_e        state;
    logic [DATA_W-1:0] prev_gpio;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              detect;
    logic              drop;
    logic              push;

    assign evt_valid = !fifo_empty;
    assign pop       = evt_valid && evt_ready;
    assign irq_out   = evt_valid || overflow_flag;
    assign log_state = state;

    // Event detection and push/drop decision for the current cycle.
    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        detect = 1'b0;
        drop   = 1'b0;
        push   = 1'b0;
        if (state == ST_LOGGING) begin
            detect = |((gpio_data_in ^ prev_gpio) & evt_mask);
        end
        drop = detect && fifo_full && !pop;
        push = detect && !drop;
    end

    // Previous GPIO word, captured every cycle in every state.
    always_ff @(posedge clk_main_200mhz or negedge reset_n) begin
        if (!reset_n) begin
            prev_gpio <= '0;
        end else begin
            prev_gpio <= gpio_data_in;
        end
    end

    // Logger FSM; a freezing drop takes priority over log_enable going low.
    always_ff @(posedge clk_main_200mhz or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (log_enable) state <= ST_LOGGING;
                end
                ST_LOGGING: begin
                    if (drop && freeze_on_ovf) state <= ST_FROZEN;
                    else if (!log_enable)      state <= ST_IDLE;
                end
                ST_FROZEN: begin
                    if (overflow_clear) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter; a new drop wins over clear.
    always_ff @(posedge clk_main_200mhz or negedge reset_n) begin
        if (!reset_n) begin
            overflow_flag <= 1'b0;
            drop_count    <= '0;
        end else if (drop) begin
            overflow_flag <= 1'b1;
            if (overflow_clear) begin
                drop_count <= 16'd1;
            end else if (drop_count != DROP_COUNT_MAX) begin
                drop_count <= drop_count + 16'd1;
            end
        end else if (overflow_clear) begin
            overflow_flag <= 1'b0;
            drop_count    <= '0;
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_main_200mhz (clk_main_200mhz),
        .reset_n         (reset_n),
        .push            (push),
        .push_data       ({timestamp_in, gpio_data_in}),
        .pop             (pop),
        .pop_data        (evt_data),
        .full            (fifo_full),
        .empty           (fifo_empty),
        .level           (fifo_level)
    );

endmodule

// File: tb/tb_gpio_event_logger.sv
// Self-checking bench for gpio_event_logger: directed vector table, hand-written
// overflow/freeze/reset sequences and randomized traffic against a queue model.
module tb_gpio_event_logger;

    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int LW    = 5;

    logic            clk_main_200mhz = 1'b0;
    logic            reset_n;
    logic [DW-1:0]   gpio_data_in;
    logic [DW-1:0]   timestamp_in;
    logic            log_enable;
    logic            freeze_on_ovf;
    logic [DW-1:0]   evt_mask;
    logic [2*DW-1:0] evt_data;
    logic            evt_valid;
    logic            evt_ready;
    logic [LW-1:0]   fifo_level;
    logic            overflow_flag;
    logic            overflow_clear;
    logic [15:0]     drop_count;
    logic            irq_out;
    logic [1:0]      log_state;

    int checks   = 0;
    int failures = 0;

    always #5 clk_main_200mhz = ~clk_main_200mhz;

    gpio_event_logger #(
        .FIFO_DEPTH (DEPTH),
        .DATA_W     (DW)
    ) dut (
        .clk_main_200mhz (clk_main_200mhz),
        .reset_n         (reset_n),
        .gpio_data_in    (gpio_data_in),
        .timestamp_in    (timestamp_in),
        .log_enable      (log_enable),
        .freeze_on_ovf   (freeze_on_ovf),
        .evt_mask        (evt_mask),
        .evt_data        (evt_data),
        .evt_valid       (evt_valid),
        .evt_ready       (evt_ready),
        .fifo_level      (fifo_level),
        .overflow_flag   (overflow_flag),
        .overflow_clear  (overflow_clear),
        .drop_count      (drop_count),
        .irq_out         (irq_out),
        .log_state       (log_state)
    );

    // ---------------- reference model ----------------
    logic [2*DW-1:0] m_q[$];
    logic [DW-1:0]   m_prev;
    int              m_state;   // 0 idle, 1 logging, 2 frozen
    bit              m_flag;
    int              m_drops;

    task automatic model_reset();
        m_q.delete();
        m_prev  = '0;
        m_state = 0;
        m_flag  = 1'b0;
        m_drops = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit pop;
        bit change;
        bit drop;
        pop    = (m_q.size() != 0) && evt_ready;
        change = (m_state == 1) && (((gpio_data_in ^ m_prev) & evt_mask) != 0);
        drop   = change && (m_q.size() == DEPTH) && !pop;
        if (pop) void'(m_q.pop_front());
        if (change && !drop) m_q.push_back({timestamp_in, gpio_data_in});
        if (drop) begin
            m_flag  = 1'b1;
            m_drops = overflow_clear ? 1 : ((m_drops < 65535) ? m_drops + 1 : 65535);
        end else if (overflow_clear) begin
            m_flag  = 1'b0;
            m_drops = 0;
        end
        if (m_state == 0 && log_enable)                   m_state = 1;
        else if (m_state == 1 && drop && freeze_on_ovf)   m_state = 2;
        else if (m_state == 1 && !log_enable)             m_state = 0;
        else if (m_state == 2 && overflow_clear)          m_state = 0;
        m_prev = gpio_data_in;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic compare_model(input string tag);
        logic [63:0] exp_head;
        exp_head = (m_q.size() != 0) ? m_q[0] : '0;
        check({tag, " evt_valid"},     evt_valid,     64'(m_q.size() != 0));
        check({tag, " evt_data"},      evt_data,      exp_head);
        check({tag, " fifo_level"},    fifo_level,    64'(m_q.size()));
        check({tag, " overflow_flag"}, overflow_flag, 64'(m_flag));
        check({tag, " drop_count"},    drop_count,    64'(m_drops));
        check({tag, " irq_out"},       irq_out,       64'((m_q.size() != 0) || m_flag));
        check({tag, " log_state"},     log_state,     64'(m_state));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " evt_valid"},     evt_valid,     0);
        check({tag, " evt_data"},      evt_data,      0);
        check({tag, " fifo_level"},    fifo_level,    0);
        check({tag, " overflow_flag"}, overflow_flag, 0);
        check({tag, " drop_count"},    drop_count,    0);
        check({tag, " irq_out"},       irq_out,       0);
        check({tag, " log_state"},     log_state,     0);
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk_main_200mhz);
        #1;
        compare_model(tag);
    endtask

    task automatic apply_reset();
        reset_n        = 1'b0;
        log_enable     = 1'b0;
        freeze_on_ovf  = 1'b0;
        evt_ready      = 1'b0;
        overflow_clear = 1'b0;
        gpio_data_in   = '0;
        timestamp_in   = '0;
        evt_mask       = '0;
        repeat (2) @(posedge clk_main_200mhz);
        #1;
        check_reset_outputs("in_reset");
        reset_n = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        le;
        logic [31:0] mask;
        logic [31:0] gpio;
        logic [31:0] ts;
        logic        rdy;
        logic        exp_valid;
        logic [63:0] exp_data;
        int          exp_level;
        logic [1:0]  exp_state;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [31:0] mask_tbl[4];
        int          rdy_pct;

        vecs[0] = '{1'b1, 32'h0000_00FF, 32'h0000_0000, 32'd98,  1'b0, 1'b0, 64'h0, 0, 2'd1, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_00FF, 32'h0000_0000, 32'd99,  1'b0, 1'b0, 64'h0, 0, 2'd1, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_00FF, 32'h0000_0001, 32'd100, 1'b0, 1'b1, {32'd100, 32'h0000_0001}, 1, 2'd1, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_00FF, 32'h0000_0001, 32'd101, 1'b1, 1'b0, 64'h0, 0, 2'd1, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_FFFF, 32'h0001_0001, 32'd102, 1'b0, 1'b0, 64'h0, 0, 2'd1, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_FFFF, 32'h0001_0003, 32'd200, 1'b0, 1'b1, {32'd200, 32'h0001_0003}, 1, 2'd1, 1'b1};
        vecs[6] = '{1'b0, 32'h0000_FFFF, 32'h0001_0003, 32'd201, 1'b0, 1'b1, {32'd200, 32'h0001_0003}, 1, 2'd0, 1'b1};
        vecs[7] = '{1'b0, 32'h0000_FFFF, 32'h0001_0005, 32'd300, 1'b0, 1'b1, {32'd200, 32'h0001_0003}, 1, 2'd0, 1'b1};
        vecs[8] = '{1'b0, 32'h0000_FFFF, 32'h0001_0005, 32'd301, 1'b1, 1'b0, 64'h0, 0, 2'd0, 1'b0};

        apply_reset();
        for (int i = 0; i < 9; i++) begin
            log_enable   = vecs[i].le;
            evt_mask     = vecs[i].mask;
            gpio_data_in = vecs[i].gpio;
            timestamp_in = vecs[i].ts;
            evt_ready    = vecs[i].rdy;
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d tbl evt_valid", i),  evt_valid,  64'(vecs[i].exp_valid));
            check($sformatf("vec%0d tbl evt_data", i),   evt_data,   vecs[i].exp_data);
            check($sformatf("vec%0d tbl fifo_level", i), fifo_level, 64'(vecs[i].exp_level));
            check($sformatf("vec%0d tbl log_state", i),  log_state,  64'(vecs[i].exp_state));
            check($sformatf("vec%0d tbl irq_out", i),    irq_out,    64'(vecs[i].exp_irq));
        end

        // ---- overflow without freeze, push on full with pop, drop vs clear ----
        apply_reset();
        log_enable = 1'b1;
        evt_mask   = 32'hFFFF_FFFF;
        step("ovf_enable");
        for (int i = 1; i <= 17; i++) begin
            gpio_data_in = 32'(i);
            timestamp_in = 32'(1000 + i);
            step($sformatf("ovf_ev%0d", i));
        end
        check("ovf17 fifo_level",    fifo_level,    16);
        check("ovf17 overflow_flag", overflow_flag, 1);
        check("ovf17 drop_count",    drop_count,    1);
        check("ovf17 log_state",     log_state,     1);
        check("ovf17 head",          evt_data,      {32'd1001, 32'd1});

        gpio_data_in = 32'd18;
        timestamp_in = 32'd1018;
        evt_ready    = 1'b1;
        step("full_push_pop");
        evt_ready    = 1'b0;
        check("full_push_pop fifo_level", fifo_level, 16);
        check("full_push_pop drop_count", drop_count, 1);

        gpio_data_in = 32'd19;
        timestamp_in = 32'd1019;
        step("second_drop");
        check("second_drop drop_count", drop_count, 2);
        gpio_data_in   = 32'd20;
        timestamp_in   = 32'd1020;
        overflow_clear = 1'b1;
        step("drop_and_clear");
        overflow_clear = 1'b0;
        check("drop_and_clear overflow_flag", overflow_flag, 1);
        check("drop_and_clear drop_count",    drop_count,    1);

        evt_ready = 1'b1;
        for (int k = 2; k <= 12; k++) begin
            check($sformatf("order head%0d", k), evt_data, {32'(1000 + k), 32'(k)});
            step($sformatf("drain%0d", k));
        end
        evt_ready = 1'b0;
        check("five_left fifo_level", fifo_level, 5);

        // ---- asynchronous reset mid-operation with entries queued ----
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        apply_reset();
        log_enable   = 1'b1;
        gpio_data_in = 32'hFFFF_FFFF;
        evt_mask     = 32'hFFFF_FFFF;
        step("first_after_release");
        check("first_after_release fifo_level", fifo_level, 0);
        check("first_after_release log_state",  log_state,  1);

        // ---- freeze on overflow ----
        apply_reset();
        log_enable    = 1'b1;
        freeze_on_ovf = 1'b1;
        evt_mask      = 32'hFFFF_FFFF;
        step("frz_enable");
        for (int i = 1; i <= 17; i++) begin
            gpio_data_in = 32'(i);
            timestamp_in = 32'(2000 + i);
            step($sformatf("frz_ev%0d", i));
        end
        check("frz log_state",     log_state,     2);
        check("frz overflow_flag", overflow_flag, 1);
        check("frz drop_count",    drop_count,    1);
        gpio_data_in = 32'd100;
        step("frz_ignored");
        check("frz_ignored fifo_level", fifo_level, 16);
        check("frz_ignored drop_count", drop_count, 1);
        evt_ready = 1'b1;
        step("frz_drain");
        evt_ready = 1'b0;
        check("frz_drain fifo_level", fifo_level, 15);
        gpio_data_in = 32'd101;
        step("frz_ignored2");
        check("frz_ignored2 fifo_level", fifo_level, 15);
        overflow_clear = 1'b1;
        step("frz_clear");
        overflow_clear = 1'b0;
        check("frz_clear log_state",     log_state,     0);
        check("frz_clear overflow_flag", overflow_flag, 0);
        check("frz_clear drop_count",    drop_count,    0);
        evt_ready = 1'b1;
        for (int i = 0; i < 15; i++) step($sformatf("frz_empty%0d", i));
        evt_ready = 1'b0;
        check("frz_empty fifo_level", fifo_level, 0);

        // ---- randomized traffic against the model ----
        mask_tbl[0] = 32'hFFFF_FFFF;
        mask_tbl[1] = 32'h0000_00FF;
        mask_tbl[2] = 32'h0000_FF00;
        mask_tbl[3] = 32'h0000_0000;
        rdy_pct     = 50;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) apply_reset();
            if (c % 200 == 0) rdy_pct = (c / 200) % 3 == 0 ? 10 : ((c / 200) % 3 == 1 ? 50 : 90);
            if (c % 50 == 0) evt_mask = mask_tbl[$urandom_range(0, 3)];
            log_enable     = ($urandom_range(0, 19) != 0);
            freeze_on_ovf  = ($urandom_range(0, 3) == 0);
            overflow_clear = ($urandom_range(0, 63) == 0);
            evt_ready      = ($urandom_range(0, 99) < rdy_pct);
            if ($urandom_range(0, 1) == 1) gpio_data_in = gpio_data_in ^ (32'd1 << $urandom_range(0, 31));
            timestamp_in = 32'(c);
            step($sformatf("rand%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
